// File: rtl/encoder_arb_nw.sv
// encoder_arb_nw: registered N-wide priority encoder with an optional
// round-robin pointer. The output is held under a valid/ready handshake.
// While the consumer stalls, y and multi are frozen. A new winner is
// loaded only when the output slot is empty or is being accepted.
module encoder_arb_nw #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] y,
    output logic                 v,
    output logic                 multi,
    input  logic                 rdy
);

    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic           multi_q, multi_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   win;
    logic           any_req;
    logic           load;
    logic           accept;

    assign any_req = |req;
    assign accept  = (state_q == HOLD) && rdy;
    assign load    = (state_q == IDLE) || rdy;

    // Rotation pointer. It advances past the grant being accepted on this
    // edge and wraps from N-1 to 0. Fixed-priority mode keeps it at 0.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 1 && accept) begin
            ptr_d = (y_q == W'(N - 1)) ? '0 : y_q + 1'b1;
        end
    end

    // Winner search from the already-updated pointer. This lets a grant
    // accepted and a reload on the same edge rotate correctly.
    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_d) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[W-1:0]]) begin
                win   = idx[W-1:0];
                found = 1'b1;
            end
        end
    end

    // Next-state and output-register logic. The slot reloads when empty
    // or being accepted, and holds otherwise.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        multi_d = multi_q;
        if (load) begin
            if (any_req) begin
                state_d = HOLD;
                y_d     = win;
                multi_d = ($countones(req) > 1);
            end else begin
                state_d = IDLE;
                y_d     = '0;
                multi_d = 1'b0;
            end
        end
    end

    // State, output and pointer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            multi_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y     = y_q;
    assign v     = (state_q == HOLD);
    assign multi = multi_q;

endmodule
